// File: rtl/systolic_conv_1d_stream_pkg.sv
// Shared FSM state type and the round/saturate helper for the 1-D systolic convolution engine.
package conv1d_pkg;
  localparam int SHIFT_W  = 5;
  localparam int STRIDE_W = 2;
  localparam int WIDE_W   = 64;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_e;

  // Round half-up at the shift point, arithmetic shift, then clamp to a dw-bit signed range.
  function automatic logic signed [WIDE_W-1:0] sat_round(
    input logic signed [WIDE_W-1:0] acc,
    input logic [SHIFT_W-1:0]       shift,
    input int                       dw
  );
    logic signed [WIDE_W-1:0] r, v, hi, lo;
    r = acc;
    if (shift != '0) r = acc + (WIDE_W'(1) <<< (shift - SHIFT_W'(1)));
    v  = r >>> shift;
    hi = (WIDE_W'(1) <<< (dw - 1)) - WIDE_W'(1);
    lo = -(WIDE_W'(1) <<< (dw - 1));
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction
endpackage

// File: rtl/systolic_conv_1d_stream_if.sv
// Kernel-write, configuration, sample-in and result-out signals of the convolution engine.
interface systolic_conv_1d_stream_if #(
  parameter int NUM_PE     = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TAP_W      = $clog2(NUM_PE + 1),
  parameter int ADDR_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
);
  import conv1d_pkg::*;

  logic                         kernel_we;
  logic [ADDR_W-1:0]            kernel_addr;
  logic signed [DATA_WIDTH-1:0] kernel_data;
  logic [TAP_W-1:0]             cfg_taps;
  logic [STRIDE_W-1:0]          cfg_stride;
  logic [SHIFT_W-1:0]           cfg_shift;
  logic                         cfg_full;
  logic                         start;
  logic                         cfg_err;
  logic                         busy;
  logic signed [DATA_WIDTH-1:0] x_data;
  logic                         x_valid;
  logic                         x_last;
  logic                         x_ready;
  logic signed [DATA_WIDTH-1:0] y_data;
  logic                         y_valid;
  logic                         y_ready;

  modport slave (
    input  kernel_we, kernel_addr, kernel_data, cfg_taps, cfg_stride, cfg_shift, cfg_full, start,
    input  x_data, x_valid, x_last, y_ready,
    output cfg_err, busy, x_ready, y_data, y_valid
  );

  modport master (
    output kernel_we, kernel_addr, kernel_data, cfg_taps, cfg_stride, cfg_shift, cfg_full, start,
    output x_data, x_valid, x_last, y_ready,
    input  cfg_err, busy, x_ready, y_data, y_valid
  );
endinterface

// File: rtl/systolic_conv_1d_stream_pe.sv
// One transposed-form FIR tap: coefficient register, signed multiply, add-in and accumulator.
module conv1d_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_coef_we,
  input  logic signed [DATA_WIDTH-1:0] i_coef,
  input  logic                         i_clear,
  input  logic                         i_step,
  input  logic                         i_active,
  input  logic                         i_last,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  input  logic signed [ACC_WIDTH-1:0]  i_acc_in,
  output logic signed [ACC_WIDTH-1:0]  o_acc,
  output logic signed [ACC_WIDTH-1:0]  o_sum
);
  logic signed [DATA_WIDTH-1:0]   r_coef;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_add_in;

  assign w_prod   = r_coef * i_x;
  // The last active tap starts the chain, so it takes no contribution from its neighbour.
  assign w_add_in = i_last ? '0 : i_acc_in;
  assign o_sum    = w_add_in + ACC_WIDTH'(w_prod);
  assign o_acc    = r_acc;

  // NOTE: sequential state uses non-blocking assignments so every tap samples its neighbour's
  // pre-edge value; blocking here would ripple one sample through the whole chain in one edge.
  // NOTE: the coefficient store is reset explicitly so a reset leaves no stale kernel behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coef <= '0;
      r_acc  <= '0;
    end else begin
      if (i_coef_we) r_coef <= i_coef;
      if (i_clear)                 r_acc <= '0;
      else if (i_step && i_active) r_acc <= o_sum;
    end
  end
endmodule

// File: rtl/systolic_conv_1d_stream.sv
// Streaming 1-D signed convolution: frame FSM, keep/stride counters, PE chain and output register.
module systolic_conv_1d_stream
  import conv1d_pkg::*;
#(
  parameter int NUM_PE     = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 4,
  parameter int TAP_W      = $clog2(NUM_PE + 1)
) (
  input logic                    clk,
  input logic                    reset_n,
  systolic_conv_1d_stream_if.slave bus
);
  localparam int ADDR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  state_e                       r_state;
  logic [TAP_W-1:0]             r_taps;
  logic [STRIDE_W-1:0]          r_stride;
  logic [SHIFT_W-1:0]           r_shift;
  logic                         r_full;
  logic [TAP_W-1:0]             r_step_cnt;
  logic [STRIDE_W-1:0]          r_stride_cnt;
  logic [TAP_W-1:0]             r_flush_cnt;
  logic                         r_busy;
  logic                         r_cfg_err;
  logic signed [DATA_WIDTH-1:0] r_y_data;
  logic                         r_y_valid;

  logic signed [ACC_WIDTH-1:0]  w_acc [0:NUM_PE];
  logic signed [ACC_WIDTH-1:0]  w_sum [0:NUM_PE-1];
  logic signed [DATA_WIDTH-1:0] w_x;
  logic w_slot_free, w_x_ready, w_inject, w_step, w_keep, w_emit;
  logic w_cfg_legal, w_start_ok, w_start_bad, w_kernel_we;

  assign w_slot_free = !r_y_valid || bus.y_ready;
  assign w_x_ready   = (r_state == RUN) && w_slot_free;
  assign w_inject    = (r_state == FLUSH) && w_slot_free;
  assign w_step      = (bus.x_valid && w_x_ready) || w_inject;
  assign w_x         = w_inject ? '0 : bus.x_data;
  // Valid mode drops the first K-1 steps; the step counter saturates at K-1.
  assign w_keep      = r_full || (r_step_cnt == r_taps - TAP_W'(1));
  assign w_emit      = w_step && w_keep && (r_stride_cnt == '0);

  assign w_cfg_legal = (bus.cfg_taps != '0) && (bus.cfg_taps <= TAP_W'(NUM_PE));
  assign w_start_ok  = bus.start && (r_state == IDLE) && w_cfg_legal;
  assign w_start_bad = bus.start && (r_state == IDLE) && !w_cfg_legal;
  assign w_kernel_we = bus.kernel_we && !r_busy;

  assign w_acc[NUM_PE] = '0;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    conv1d_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_coef_we(w_kernel_we && (bus.kernel_addr == ADDR_W'(k))),
      .i_coef   (bus.kernel_data),
      .i_clear  (w_start_ok),
      .i_step   (w_step),
      .i_active (TAP_W'(k) < r_taps),
      .i_last   (TAP_W'(k) == r_taps - TAP_W'(1)),
      .i_x      (w_x),
      .i_acc_in (w_acc[k+1]),
      .o_acc    (w_acc[k]),
      .o_sum    (w_sum[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_taps       <= '0;
      r_stride     <= '0;
      r_shift      <= '0;
      r_full       <= 1'b0;
      r_step_cnt   <= '0;
      r_stride_cnt <= '0;
      r_flush_cnt  <= '0;
      r_busy       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_y_data     <= '0;
      r_y_valid    <= 1'b0;
    end else begin
      r_cfg_err <= w_start_bad;

      // A new result may replace the one being consumed in the same cycle.
      if (w_emit) begin
        r_y_data  <= DATA_WIDTH'(sat_round(WIDE_W'(w_sum[0]), r_shift, DATA_WIDTH));
        r_y_valid <= 1'b1;
      end else if (bus.y_ready) begin
        r_y_valid <= 1'b0;
      end

      if (w_step) begin
        if (!w_keep) r_step_cnt <= r_step_cnt + TAP_W'(1);
        else         r_stride_cnt <= (r_stride_cnt == r_stride) ? '0 : r_stride_cnt + STRIDE_W'(1);
      end

      case (r_state)
        IDLE: if (w_start_ok) begin
          r_taps       <= bus.cfg_taps;
          r_stride     <= bus.cfg_stride;
          r_shift      <= bus.cfg_shift;
          r_full       <= bus.cfg_full;
          r_step_cnt   <= '0;
          r_stride_cnt <= '0;
          r_busy       <= 1'b1;
          r_state      <= RUN;
        end
        RUN: if (w_step && bus.x_last) begin
          r_flush_cnt <= r_taps - TAP_W'(1);
          r_state     <= (r_full && r_taps > TAP_W'(1)) ? FLUSH : DRAIN;
        end
        FLUSH: if (w_inject) begin
          r_flush_cnt <= r_flush_cnt - TAP_W'(1);
          if (r_flush_cnt == TAP_W'(1)) r_state <= DRAIN;
        end
        DRAIN: if (w_slot_free) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_err = r_cfg_err;
  assign bus.busy    = r_busy;
  assign bus.x_ready = w_x_ready;
  assign bus.y_data  = r_y_data;
  assign bus.y_valid = r_y_valid;
endmodule

// File: tb/tb_systolic_conv_1d_stream.sv
// Scoreboard bench: expected results come from a direct convolution model and are popped by a monitor.
module tb_systolic_conv_1d_stream;
  localparam int NUM_PE = 16;
  localparam int DW     = 8;
  localparam int TAP_W  = $clog2(NUM_PE + 1);
  localparam int ADDR_W = $clog2(NUM_PE);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  systolic_conv_1d_stream_if #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW)) bus ();
  systolic_conv_1d_stream #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int cur_x[$];
  int tb_h[NUM_PE];
  int ready_mode = 0;
  int out_idx = 0;
  int seen;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: y[n] = sum h[k]*x[n-k] with zero outside the frame, then keep rule, stride, round.
  function automatic int ref_round_sat(input longint acc, input int sh);
    longint d, r, v;
    d = longint'(1) << sh;
    r = acc + ((sh > 0) ? d / 2 : 0);
    if (r >= 0) v = r / d;
    else        v = -((-r + d - 1) / d);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic push_model(input int k, input int s, input int sh, input bit full);
    int n, first, last_idx, kept;
    longint acc;
    n        = cur_x.size();
    first    = full ? 0 : k - 1;
    last_idx = full ? n + k - 2 : n - 1;
    kept     = 0;
    for (int i = first; i <= last_idx; i++) begin
      acc = 0;
      for (int j = 0; j < k; j++)
        if (i - j >= 0 && i - j < n) acc += longint'(tb_h[j] * cur_x[i - j]);
      if (kept % s == 0) exp_q.push_back(ref_round_sat(acc, sh));
      kept++;
    end
  endtask

  task automatic write_kernel(input int idx, input int val);
    bus.kernel_we   = 1'b1;
    bus.kernel_addr = ADDR_W'(idx);
    bus.kernel_data = DW'(val);
    tick();
    bus.kernel_we = 1'b0;
    tb_h[idx] = val;
  endtask

  task automatic start_frame(input int k, input int st, input int sh, input bit full);
    bus.cfg_taps   = TAP_W'(k);
    bus.cfg_stride = 2'(st);
    bus.cfg_shift  = 5'(sh);
    bus.cfg_full   = full;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_sample(input int d, input bit last);
    bus.x_data  = DW'(d);
    bus.x_valid = 1'b1;
    bus.x_last  = last;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.x_ready) begin
        tick();
        bus.x_valid = 1'b0;
        bus.x_last  = 1'b0;
        return;
      end
      tick();
    end
    bus.x_valid = 1'b0;
    bus.x_last  = 1'b0;
    check("x_accept_timeout", bus.x_ready, 1);
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < cur_x.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(2) + 1) tick();
      send_sample(cur_x[i], i == cur_x.size() - 1);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_drop"}, bus.busy, 0);
    repeat (2) tick();
    check({name, "_all_outputs_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_frame(input string name, input int k, input int st, input int sh,
                           input bit full, input bit gaps);
    start_frame(k, st, sh, full);
    send_frame(gaps);
    wait_idle(name);
  endtask

  task automatic load_h123();
    write_kernel(0, 1);
    write_kernel(1, 2);
    write_kernel(2, 3);
  endtask

  // Downstream ready generator.
  initial begin
    bus.y_ready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0:       bus.y_ready = 1'b1;
        1:       bus.y_ready = ($urandom_range(3) != 0);
        default: bus.y_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every handshake on the result stream is matched against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus.y_valid && bus.y_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL y_unexpected: got %0d, expected no output", int'(bus.y_data));
        end else begin
          check($sformatf("y_data#%0d", out_idx), int'(bus.y_data), exp_q.pop_front());
        end
        out_idx++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, st, sh, n;
    bit full;
    bus.kernel_we = 0; bus.kernel_addr = '0; bus.kernel_data = '0;
    bus.cfg_taps = '0; bus.cfg_stride = '0; bus.cfg_shift = '0; bus.cfg_full = 0;
    bus.start = 0; bus.x_data = '0; bus.x_valid = 0; bus.x_last = 0;
    foreach (tb_h[i]) tb_h[i] = 0;

    #12;
    check("rst_y_valid", bus.y_valid, 0);
    check("rst_y_data", bus.y_data, 0);
    check("rst_x_ready", bus.x_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    #10 reset_n = 1'b1;
    tick();

    // Valid convolution, K=3.
    load_h123();
    cur_x = '{1, 2, 3, 4, 5};
    exp_q = '{10, 16, 22};
    run_frame("t1_valid", 3, 0, 0, 0, 0);

    // Full convolution with zero flush.
    exp_q = '{1, 4, 10, 16, 22, 22, 15};
    run_frame("t2_full", 3, 0, 0, 1, 0);

    // Stride 2, with a start and a kernel write attempted mid-frame (both must be ignored).
    exp_q = '{10, 22};
    start_frame(3, 1, 0, 0);
    bus.cfg_taps = '0; bus.start = 1'b1;
    bus.kernel_we = 1'b1; bus.kernel_addr = '0; bus.kernel_data = -8'sd7;
    tick();
    bus.start = 1'b0; bus.kernel_we = 1'b0;
    check("busy_start_no_err", bus.cfg_err, 0);
    check("busy_held", bus.busy, 1);
    send_frame(0);
    wait_idle("t3_stride");
    exp_q = '{10, 16, 22};
    run_frame("t3_kernel_kept", 3, 0, 0, 0, 0);

    // Single tap, saturation and rounding.
    write_kernel(0, 127);
    cur_x = '{127};  exp_q = '{127};  run_frame("t4_sat_hi", 1, 0, 0, 0, 0);
    cur_x = '{-128}; exp_q = '{-128}; run_frame("t4_sat_lo", 1, 0, 0, 0, 0);
    cur_x = '{127};  exp_q = '{126};  run_frame("t4_shift7", 1, 0, 7, 0, 0);

    // Back-pressure mid-frame.
    write_kernel(0, 1);
    cur_x = '{1, 2, 3, 4, 5};
    exp_q = '{1, 4, 10, 16, 22, 22, 15};
    seen = 0;
    start_frame(3, 0, 0, 1);
    fork
      send_frame(0);
      begin
        repeat (2) tick();
        ready_mode = 2;
        repeat (7) begin
          @(negedge clk);
          if (bus.y_valid && !bus.y_ready) begin
            seen++;
            check("stall_x_ready", bus.x_ready, 0);
          end
        end
        ready_mode = 0;
      end
    join
    check("stall_observed", seen > 0, 1);
    wait_idle("t5_backpressure");

    // Illegal tap counts.
    start_frame(0, 0, 0, 0);
    check("k0_cfg_err", bus.cfg_err, 1);
    check("k0_busy", bus.busy, 0);
    tick();
    check("k0_err_pulse", bus.cfg_err, 0);
    start_frame(NUM_PE + 1, 0, 0, 0);
    check("k17_cfg_err", bus.cfg_err, 1);
    check("k17_busy", bus.busy, 0);

    // Reset while stalled in the flush phase.
    ready_mode = 2;
    tick(); tick();
    start_frame(3, 0, 0, 1);
    send_sample(5, 1);
    repeat (3) tick();
    check("flush_held_valid", bus.y_valid, 1);
    check("flush_held_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_y_valid", bus.y_valid, 0);
    check("abort_y_data", bus.y_data, 0);
    check("abort_x_ready", bus.x_ready, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_cfg_err", bus.cfg_err, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    ready_mode = 0;
    tick();
    foreach (tb_h[i]) tb_h[i] = 0;
    load_h123();
    cur_x = '{1, 2, 3, 4, 5};
    exp_q = '{10, 16, 22};
    run_frame("t6_rerun", 3, 0, 0, 0, 0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      k    = $urandom_range(NUM_PE, 1);
      st   = $urandom_range(3);
      sh   = ($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(10);
      full = 1'($urandom_range(1));
      n    = $urandom_range(20, 1);
      for (int j = 0; j < NUM_PE; j++) write_kernel(j, int'($urandom_range(255)) - 128);
      cur_x.delete();
      for (int i = 0; i < n; i++) cur_x.push_back(int'($urandom_range(255)) - 128);
      ready_mode = $urandom_range(1);
      push_model(k, st + 1, sh, full);
      run_frame($sformatf("rand%0d", f), k, st, sh, full, 1);
    end
    ready_mode = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
